// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: advances a count/rotate/bounce/thermometer
// pattern once per rising edge of the clock-divider toggle output.
module led_pattern_sequencer #(
    parameter int NUM_LEDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_in,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic                load,
    input  logic [NUM_LEDS-1:0] load_value,
    output logic [NUM_LEDS-1:0] leds,
    output logic                step_pulse,
    output logic                wrap_pulse
);

    localparam int N = NUM_LEDS;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    localparam logic [1:0] MODE_COUNT  = 2'b00;
    localparam logic [1:0] MODE_ROTATE = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_THERMO = 2'b11;

    localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] ONES = {N{1'b1}};
    localparam logic [N-1:0] ZERO = {N{1'b0}};

    logic [N-1:0] leds_q, leds_d;
    logic         dir_q, dir_d;
    logic         tick_q;
    logic         step_q, step_d;
    logic         wrap_q, wrap_d;

    logic         rise;
    logic         onehot;
    logic         go_right;
    logic [N-1:0] bnc;

    assign rise = tick_in & ~tick_q;

    assign onehot = (leds_q != ZERO) &&
                    ((leds_q & (leds_q - ONE)) == ZERO);

    // A lit LED sitting at an end always reflects inward,
    // whatever direction was left over from another mode.
    assign go_right = (dir_q == RIGHT && !leds_q[0]) ||
                      (dir_q == LEFT && leds_q[N-1]);

    assign bnc = go_right ? (leds_q >> 1) : (leds_q << 1);

    always_comb begin
        leds_d = leds_q;
        dir_d  = dir_q;
        step_d = 1'b0;
        wrap_d = 1'b0;
        if (load) begin
            leds_d = load_value;
            dir_d  = LEFT;
        end else if (rise && enable) begin
            step_d = 1'b1;
            unique case (mode)
                MODE_COUNT: begin
                    leds_d = leds_q + ONE;
                    wrap_d = (leds_q == ONES);
                end
                MODE_ROTATE: begin
                    if (leds_q == ZERO) begin
                        leds_d = ONE;
                    end else begin
                        leds_d = {leds_q[N-2:0], leds_q[N-1]};
                        wrap_d = leds_q[N-1];
                    end
                end
                MODE_BOUNCE: begin
                    if (!onehot) begin
                        leds_d = ONE;
                        dir_d  = LEFT;
                    end else begin
                        leds_d = bnc;
                        if (bnc[N-1])
                            dir_d = RIGHT;
                        else if (bnc[0])
                            dir_d = LEFT;
                        else
                            dir_d = go_right ? RIGHT : LEFT;
                        wrap_d = go_right & bnc[0];
                    end
                end
                MODE_THERMO: begin
                    if (leds_q == ONES) begin
                        leds_d = ZERO;
                        wrap_d = 1'b1;
                    end else begin
                        leds_d = (leds_q << 1) | ONE;
                    end
                end
            endcase
        end
    end

    // tick_q resets high so a divider output already high is not a step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds_q <= ONE;
            dir_q  <= LEFT;
            tick_q <= 1'b1;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            leds_q <= leds_d;
            dir_q  <= dir_d;
            tick_q <= tick_in;
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    assign leds       = leds_q;
    assign step_pulse = step_q;
    assign wrap_pulse = wrap_q;

endmodule
